// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-wide data memory: alignment and
// range checks, lane extraction/extension for loads, read-modify-write for sub-word stores.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   request payload
//   rsp_valid, rsp_err,
//   rsp_rdata                   one-cycle response, rdata held until next response
//   mem_ewr, mem_erd, mem_addr,
//   mem_wdata, mem_rdata        data memory port (word index, comb read)
module lsu_mem_ctrl #(
   parameter int DEPTH_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        mem_ewr,
   output logic        mem_erd,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LD   = 3'd1;
   localparam logic [2:0] S_RMW  = 3'd2;
   localparam logic [2:0] S_STW  = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]  state;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        req_err;
   logic [4:0]  bsh;
   logic [4:0]  hsh;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ld_val;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [31:0] merged;

   // Range test is an unsigned compare of the full word index; no wrap.
   assign req_err = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (|req_addr[1:0]))
                  | ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

   assign bsh    = {req_dummy_lo(addr_q[1:0]), 3'b000};
   assign hsh    = {addr_q[1], 4'b0000};
   assign byte_v = 8'(mem_rdata >> bsh);
   assign half_v = 16'(mem_rdata >> hsh);

   function automatic logic [1:0] req_dummy_lo(input logic [1:0] v);
      return v;
   endfunction

   always_comb begin
      ld_val = mem_rdata;
      case (size_q)
         2'b00:   ld_val = {{24{~uns_q & byte_v[7]}}, byte_v};
         2'b01:   ld_val = {{16{~uns_q & half_v[15]}}, half_v};
         default: ld_val = mem_rdata;
      endcase
   end

   // Sub-word store: replace only the addressed lane of the fetched word.
   always_comb begin
      lane_mask = 32'h0000_FFFF << hsh;
      lane_data = {16'h0000, wdata_q[15:0]} << hsh;
      if (size_q == 2'b00) begin
         lane_mask = 32'h0000_00FF << bsh;
         lane_data = {24'h00_0000, wdata_q[7:0]} << bsh;
      end
      merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         merge_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  merge_q <= req_wdata;
                  err_q   <= req_err;
                  if (req_err) begin
                     rdata_q <= 32'h0;
                     state   <= S_RESP;
                  end else if (!req_we) begin
                     state <= S_LD;
                  end else if (req_size == 2'b10) begin
                     state <= S_STW;
                  end else begin
                     state <= S_RMW;
                  end
               end
            end
            S_LD: begin
               rdata_q <= ld_val;
               state   <= S_RESP;
            end
            S_RMW: begin
               merge_q <= merged;
               state   <= S_STW;
            end
            S_STW: begin
               rdata_q <= 32'h0;
               state   <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Memory strobes decode straight from state so reset kills them at once.
   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign rsp_err   = (state == S_RESP) & err_q;
   assign rsp_rdata = rdata_q;
   assign mem_erd   = ((state == S_LD) & ~we_q) | ((state == S_RMW) & we_q);
   assign mem_ewr   = (state == S_STW);
   assign mem_addr  = (state == S_LD || state == S_RMW || state == S_STW)
                    ? {2'b00, addr_q[31:2]} : 32'h0;
   assign mem_wdata = (state == S_STW) ? merge_q : 32'h0;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller placed directly upstream of the data memory in the memory stage. It accepts one byte, halfword or word access per request from the execute stage and checks alignment and range. It drives the memory's word-wide write-enable, read-enable, address and write-data inputs, and returns sign- or zero-extended load data. The memory only writes whole words, so sub-word stores are done as a read-modify-write sequence.

## Interface
- DEPTH_WORDS, 32, number of 32-bit words in the attached data memory; word index ≥ DEPTH_WORDS is out of range
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal (treated as misaligned)
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for word and stores
- req_addr  in  32  byte address, little-endian lanes
- req_wdata  in  32  store data, sub-word data right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; 1 = misaligned, illegal size or out of range, no memory access made
- rsp_rdata  out  32  load result; 0 for stores and errors; held until next response
- mem_ewr  out  1  memory write enable
- mem_erd  out  1  memory read enable
- mem_addr  out  32  word index = latched req_addr[31:2]
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- States: IDLE, LD, RMW_RD, ST_W, RESP.
- IDLE: req_ready=1. On req_valid=1, latch we, size, unsigned, addr and wdata, then:
  - Error if size=11, or halfword with addr[0]=1, or word with addr[1:0]≠00, or addr[31:2] ≥ DEPTH_WORDS. Go to RESP with err=1 and rdata=0.
  - Load → LD.
  - Word store → ST_W, with merge register = wdata.
  - Byte or halfword store → RMW_RD.
- LD: mem_erd=1. Capture mem_rdata and extract the lane:
  - Byte lane k = addr[1:0] → bits [8k+7:8k].
  - Halfword lane addr[1] → bits [16·addr[1]+15 : 16·addr[1]].
  - Extend to 32 bits per req_unsigned into rsp_rdata, then → RESP.
- RMW_RD: mem_erd=1. Capture mem_rdata into the merge register, replacing the addressed byte with wdata[7:0] or the halfword with wdata[15:0]. Other bits are unchanged. → ST_W.
- ST_W: mem_ewr=1, mem_erd=0, mem_wdata = merge register, then → RESP.
- RESP: rsp_valid=1 and rsp_err as latched, then → IDLE.
- Outside their active states, mem_ewr and mem_erd are 0. mem_addr and mem_wdata are 0 in IDLE and RESP.
- mem_ewr and mem_erd are never both 1.
- mem_* outputs are decoded from the state register plus the latched request.

## Timing
- Edge 0 is the edge that accepts the request.
- Load: LD in cycle 1, rsp_valid in cycle 2. Latency 2 cycles.
- Word store: ST_W in cycle 1, rsp_valid in cycle 2.
- Sub-word store: RMW_RD in cycle 1, ST_W in cycle 2, rsp_valid in cycle 3.
- Error: rsp_valid in cycle 1, no mem_erd or mem_ewr assertion.
- The next request can be accepted on the edge after RESP. req_ready is low from edge 0 until IDLE is re-entered.
- Inputs are ignored while req_ready=0. The requester must hold req_valid with a stable payload until it is accepted.
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All latched registers go to 0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_ewr=0, mem_erd=0, mem_addr=0, mem_wdata=0.
  - req_ready=1 once rst_n is high.
- Reset during RMW_RD or ST_W aborts the access. mem_ewr drops the same instant, so no partial write happens after the reset edge.
- Address wrap: addr[31:2] is compared unsigned to DEPTH_WORDS. There is no modulo wrap, and large addresses are errors.

## Test plan
- Word store addr 0x0000_0010, wdata 0xDEAD_BEEF → ST_W in cycle 1 with mem_addr=4, mem_wdata=0xDEAD_BEEF; rsp_valid in cycle 2 with rdata=0 and err=0. Then word load from the same address → rsp_rdata=0xDEAD_BEEF in cycle 2.
- Word at index 4 = 0xDEAD_BEEF; signed byte load at addr 0x11 → 0xFFFF_FFBE; unsigned byte load → 0x0000_00BE; signed halfword load at addr 0x12 → 0xFFFF_DEAD.
- Byte store addr 0x13, wdata 0x0000_0012, over 0xDEAD_BEEF → RMW_RD then ST_W with mem_wdata=0x12AD_BEEF, rsp in cycle 3. A subsequent word load returns 0x12AD_BEEF.
- Misaligned and illegal requests each give rsp_valid in cycle 1 with err=1 and rdata=0, and mem_ewr and mem_erd stay 0 throughout. Cases: halfword load at addr 0x01, word store at addr 0x02, size=11, and word load at addr 0x80 (index 32 = DEPTH_WORDS).
- Back-to-back: req_valid held high with two loads queued → the second is accepted only on the edge after the first RESP, and req_ready=0 in between.
- Assert rst_n=0 mid-cycle during ST_W of a halfword store → mem_ewr falls immediately and the memory word stays unchanged. After release, req_ready=1, rsp_valid=0 and rsp_rdata=0.
